// File: rtl/cache_req_arbiter.sv
// ============================================================================
// cache_req_arbiter : round-robin request arbiter and access sequencer that
//                     shares one cacheSim instance between NUM_REQ requesters
// Revision          : 1.0
// ============================================================================
`default_nettype none

module cache_req_arbiter #(
  parameter int  NUM_REQ      = 2,
  parameter int  ADDRESS_SIZE = 16,
  parameter int  MISS_PENALTY = 4,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ-1:0]              req_rw_i,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            rw_o,
  output logic [ADDRESS_SIZE-1:0]         address_o,
  output logic                            cache_en_o,
  input  logic                            cache_hit_i,
  output logic                            rsp_valid_o,
  output logic [ID_W-1:0]                 rsp_id_o,
  output logic                            rsp_hit_o,
  output logic                            busy_o
);

  localparam int CNT_W = $clog2(MISS_PENALTY + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RESOLVE = 2'd2;
  localparam logic [1:0] S_STALL   = 2'd3;

  logic [1:0]              state_q,     state_d;
  logic [ID_W-1:0]         ptr_q,       ptr_d;
  logic [ID_W-1:0]         id_q,        id_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic                    rw_q,        rw_d;
  logic [ADDRESS_SIZE-1:0] addr_q,      addr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]         rsp_id_q,    rsp_id_d;
  logic                    rsp_hit_q,   rsp_hit_d;

  logic                    found;
  logic [ID_W-1:0]         win;
  logic [ID_W:0]           cand;
  logic                    transfer;

  // Search upward from the pointer, wrapping modulo NUM_REQ; one extra bit
  // keeps ptr+k from overflowing before the wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid_i[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
  end

  assign transfer = (state_q == S_IDLE) && found;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = transfer && (win == ID_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_hit_d   = rsp_hit_q;

    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          rw_d    = req_rw_i[win];
          addr_d  = req_addr_i[win*ADDRESS_SIZE +: ADDRESS_SIZE];
          id_d    = win;
          ptr_d   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (cache_hit_i) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_id_d    = id_q;
          state_d     = S_IDLE;
        end else begin
          cnt_d   = CNT_W'(MISS_PENALTY);
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (cnt_q == CNT_W'(1)) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b0;
          rsp_id_d    = id_q;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_hit_q   <= rsp_hit_d;
    end
  end

  assign rw_o        = rw_q;
  assign address_o   = addr_q;
  assign cache_en_o  = (state_q == S_ISSUE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cache_req_arbiter.sv
// ============================================================================
// tb_cache_req_arbiter : scoreboard bench for cache_req_arbiter (3 requesters)
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_cache_req_arbiter;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int MP = 4;
  localparam int IW = $clog2(NR);

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [NR-1:0]     req_valid_i = '0;
  logic [NR-1:0]     req_rw_i = '0;
  logic [NR*AW-1:0]  req_addr_i = '0;
  logic [NR-1:0]     req_ready_o;
  logic              rw_o;
  logic [AW-1:0]     address_o;
  logic              cache_en_o;
  logic              cache_hit_i = 1'b0;
  logic              rsp_valid_o;
  logic [IW-1:0]     rsp_id_o;
  logic              rsp_hit_o;
  logic              busy_o;

  cache_req_arbiter #(
    .NUM_REQ      (NR),
    .ADDRESS_SIZE (AW),
    .MISS_PENALTY (MP)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_rw_i    (req_rw_i),
    .req_addr_i  (req_addr_i),
    .req_ready_o (req_ready_o),
    .rw_o        (rw_o),
    .address_o   (address_o),
    .cache_en_o  (cache_en_o),
    .cache_hit_i (cache_hit_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_hit_o   (rsp_hit_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { int id; bit hit; } rsp_t;
  typedef struct { bit rw; logic [AW-1:0] addr; } iss_t;
  rsp_t rsp_q[$];
  iss_t iss_q[$];

  // Reference model: m_wait counts cycles until the arbiter is idle again.
  int            m_wait = 0;
  int            m_ptr = 0;
  bit            m_en = 0;
  bit            m_rsp = 0;
  bit            en_last = 0;

  always @(negedge clk_i) begin
    int            w;
    int            idx;
    logic [NR-1:0] exp_rdy;
    logic [AW-1:0] a;
    bit            h;
    rsp_t          r;
    iss_t          s;
    if (reset_i) begin
      m_wait = 0; m_ptr = 0; m_en = 0; m_rsp = 0; en_last = 0;
      rsp_q.delete(); iss_q.delete();
      cache_hit_i = 1'b0;
    end else begin
      w = -1;
      exp_rdy = '0;
      if (m_wait == 0) begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (w < 0 && req_valid_i[idx]) w = idx;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
      chk("busy", 32'(busy_o), 32'(m_wait != 0));
      chk("cache_en", 32'(cache_en_o), 32'(m_en));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(m_rsp));
      if (cache_en_o) begin
        if (iss_q.size() == 0) chk("issue_extra", 32'(1), 32'(0));
        else begin
          s = iss_q.pop_front();
          chk("issue_rw", 32'(rw_o), 32'(s.rw));
          chk("issue_addr", 32'(address_o), 32'(s.addr));
        end
      end
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) chk("rsp_extra", 32'(1), 32'(0));
        else begin
          r = rsp_q.pop_front();
          chk("rsp_id", 32'(rsp_id_o), 32'(r.id));
          chk("rsp_hit", 32'(rsp_hit_o), 32'(r.hit));
        end
      end
      // Cache answers hit for even addresses; noise when not resolving.
      cache_hit_i = en_last ? ~address_o[0] : 1'($urandom);
      en_last = cache_en_o;
      m_en = 0;
      m_rsp = 0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_rsp = 1;
      end else if (w >= 0) begin
        a = req_addr_i[w*AW +: AW];
        h = ~a[0];
        iss_q.push_back('{rw: req_rw_i[w], addr: a});
        rsp_q.push_back('{id: w, hit: h});
        m_wait = h ? 2 : MP + 2;
        m_en = 1;
        m_ptr = (w + 1) % NR;
      end
    end
  end

  task automatic send(input int i, input bit rw, input logic [AW-1:0] a);
    bit got;
    got = 0;
    req_rw_i[i] = rw;
    req_addr_i[i*AW +: AW] = a;
    req_valid_i[i] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (req_ready_o[i]) begin got = 1; break; end
    end
    if (!got) chk("grant_timeout", 32'(0), 32'(1));
    @(posedge clk_i); #1;
    req_valid_i[i] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'(0));
    chk({tag, "_en"}, 32'(cache_en_o), 32'(0));
    chk({tag, "_rspv"}, 32'(rsp_valid_o), 32'(0));
    chk({tag, "_rw"}, 32'(rw_o), 32'(0));
    chk({tag, "_addr"}, 32'(address_o), 32'(0));
    chk({tag, "_rspid"}, 32'(rsp_id_o), 32'(0));
    chk({tag, "_rsphit"}, 32'(rsp_hit_o), 32'(0));
    chk({tag, "_ready"}, 32'(req_ready_o), 32'(0));
  endtask

  initial begin
    bit seen;
    #12;
    check_idle_outputs("reset");
    @(posedge clk_i); #1 reset_i = 1'b0;
    repeat (2) @(posedge clk_i); #1;

    // single hit then single miss
    send(0, 1'b0, 16'h1234);
    repeat (8) @(posedge clk_i); #1;
    send(1, 1'b1, 16'hBEEF);
    repeat (12) @(posedge clk_i); #1;

    // two requesters, continuous, all hits (back-to-back in rsp cycle)
    req_rw_i = 3'b010;
    req_addr_i = {16'h0000, 16'h2222, 16'h1110};
    req_valid_i = 3'b011;
    repeat (13) @(posedge clk_i); #1;
    req_valid_i = '0;
    repeat (8) @(posedge clk_i); #1;

    // requesters 0 and 2, requester 1 idle, mixed hit and miss
    req_addr_i = {16'h5556, 16'h7777, 16'h9999};
    req_rw_i = 3'b100;
    req_valid_i = 3'b101;
    repeat (24) @(posedge clk_i); #1;
    req_valid_i = '0;
    repeat (12) @(posedge clk_i); #1;

    // reset pulsed while stalling on a miss
    send(1, 1'b1, 16'h0F0F);
    repeat (3) @(posedge clk_i);
    #3 reset_i = 1'b1;
    #1 check_idle_outputs("async_rst");
    @(posedge clk_i); @(posedge clk_i); #1 reset_i = 1'b0;
    repeat (10) @(posedge clk_i); #1;

    // first grant after reset goes to requester 0
    req_addr_i = {16'h0000, 16'h4444, 16'h6666};
    req_rw_i = '0;
    req_valid_i = 3'b011;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_i);
      if (req_ready_o != '0) begin
        seen = 1;
        chk("post_rst_grant", 32'(req_ready_o), 32'(3'b001));
      end
    end
    if (!seen) chk("post_rst_timeout", 32'(0), 32'(1));
    @(posedge clk_i); #1;
    req_valid_i = '0;
    repeat (15) @(posedge clk_i); #1;

    chk("rsp_q_empty", 32'(rsp_q.size()), 32'(0));
    chk("iss_q_empty", 32'(iss_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
